// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared types and helpers for the FIFO read-port arbiter.
package fifo_rd_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Width of the beat, idle and starvation counters.
  localparam int CNT_W = 8;

  // Index of the set bit in a one-hot vector. The vector is at most 8 bits
  // wide, which covers the largest supported requester count.
  function automatic int onehot_to_idx(input logic [7:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Bundle of the FIFO read side and the consumer-side grant/data signals.
//
// Handshake: a beat for consumer i moves on the rising edge where valid[i]
// and ready[i] are both high. valid never waits for ready, ready may look at
// valid, and data carries the beat whenever valid is high.
interface fifo_rd_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  empty;
  logic                  almost_empty;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_en;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  // FIFO plus consumers: drive flags, head word and requests.
  modport master (
    output empty, almost_empty, r_data, req, ready,
    input  r_en, gnt, valid, data, last
  );

  // The arbiter itself.
  modport slave (
    input  empty, almost_empty, r_data, req, ready,
    output r_en, gnt, valid, data, last
  );
endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   pick,
  output logic               found
);

  logic [2*NUM_REQ-1:0] req2;
  logic [2*NUM_REQ-1:0] shifted;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W:0]       sum;

  // Rotate requests so rr_ptr lands on bit 0, then take the lowest set bit.
  always_comb begin
    req2    = {req, req};
    shifted = req2 >> rr_ptr;
    rot     = shifted[NUM_REQ-1:0];
    pick    = '0;
    found   = 1'b0;
    sum     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
        if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
        pick  = sum[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing a show-ahead FIFO read port between NUM_REQ
// consumers in bounded bursts, with one idle bubble between grants.
// Optional macro FIFO_RD_ARB_WATERMARK_EN: hold grants while almost_empty
// until a requester has waited STARVE_CYCLES, so reads batch into fuller
// bursts.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter  int NUM_REQ       = 3,
  parameter  int DATA_WIDTH    = 8,
  parameter  int BURST_LEN     = 4,
  parameter  int IDLE_TIMEOUT  = 8,
  parameter  int STARVE_CYCLES = 16,
  localparam int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  fifo_rd_arbiter_if.slave   bus,
  output state_t             dbg_state,
  output logic [IDX_W-1:0]   dbg_rr_ptr
);

  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(IDLE_TIMEOUT - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 255 ||
      IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255 ||
      STARVE_CYCLES < 1 || STARVE_CYCLES > 256) begin : g_bad_cfg
    $error("fifo_rd_arbiter: parameter out of range");
  end

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [CNT_W-1:0]   idle_cnt_q;

  logic [IDX_W-1:0]   pick;
  logic               found;
  logic [7:0]         gnt_ext;
  logic [IDX_W-1:0]   g_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic               in_burst;
  logic               req_g;
  logic               ready_g;
  logic               xfer;
  logic               last_c;
  logic               exit_c;
  logic               grant_ok;
  logic               grant_c;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .found  (found)
  );

`ifdef FIFO_RD_ARB_WATERMARK_EN
  localparam logic [CNT_W-1:0] STARVE_THR = CNT_W'(STARVE_CYCLES - 1);
  logic [CNT_W-1:0] starve_cnt_q;

  // Grant when the FIFO is comfortably full, or when a waiter has starved.
  always_comb begin
    grant_ok = !bus.almost_empty || (starve_cnt_q >= STARVE_THR);
  end

  // Count IDLE cycles spent holding off a serviceable request.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else if (state_q == IDLE && grant_c) begin
      starve_cnt_q <= '0;
    end else if (state_q == IDLE && (|bus.req) && !bus.empty && bus.almost_empty) begin
      starve_cnt_q <= starve_cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_almost_empty;
  assign unused_almost_empty = bus.almost_empty;

  // Without watermarking any non-empty FIFO is worth a grant.
  always_comb begin
    grant_ok = 1'b1;
  end
`endif

  // Burst-side decode: who is granted, whether a beat moves, when to stop.
  always_comb begin
    gnt_ext              = '0;
    gnt_ext[NUM_REQ-1:0] = gnt_q;
    g_idx    = IDX_W'(onehot_to_idx(gnt_ext));
    next_ptr = (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + IDX_W'(1);
    in_burst = (state_q == BURST) && !rst;
    req_g    = |(bus.req & gnt_q);
    ready_g  = |(bus.ready & gnt_q);
    xfer     = in_burst && !bus.empty && ready_g;
    last_c   = in_burst && !bus.empty && (beat_cnt_q == LAST_BEAT);
    exit_c   = (xfer && last_c) || (!req_g && !xfer) ||
               ((idle_cnt_q == TIMEOUT_M1) && bus.empty);
    grant_c  = found && !bus.empty && grant_ok;
  end

  // Arbitration FSM with grant, pointer and burst counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_c) begin
            state_q    <= BURST;
            gnt_q      <= NUM_REQ'(1) << pick;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
          end
        end
        BURST: begin
          if (xfer) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            idle_cnt_q <= '0;
          end else if (bus.empty) begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
          end
          if (exit_c) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= next_ptr;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Pop only on an accepted beat; xfer already excludes reset and empty.
  assign bus.r_en  = xfer;
  assign bus.gnt   = gnt_q;
  assign bus.valid = (in_burst && !bus.empty) ? gnt_q : '0;
  assign bus.last  = last_c;
  assign bus.data  = bus.r_data;

  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule
